mc_control_hs: RTL and testbench

- Parametrised next-generation multicycle control unit for the 4-bit-opcode processor.
- Same control-signal contract to the datapath, same instruction set, same per-state control values.
- Adds:
  - a ready handshake for variable-latency memory, with a timeout;
  - a sticky halt state for stop, illegal opcodes and bus errors;
  - a retired-instruction counter.

---
 rtl/mc_control_hs_if.sv | 42 ++++
 rtl/mc_control_hs.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_control_hs.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_hs_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller takes the master modport; the datapath side takes slave.
interface mc_control_hs_if #(
    parameter int unsigned CNT_W = 16
);
    logic             N;
    logic             Z;
    logic [3:0]       instr;
    logic             mem_ready;
    logic             PCwrite;
    logic             MemRead;
    logic             MemWrite;
    logic             IRload;
    logic             R1Sel;
    logic             MDRload;
    logic             R1R2Load;
    logic             ALU1;
    logic             ALUOutWrite;
    logic             RFWrite;
    logic             RegIn;
    logic             FlagWrite;
    logic [2:0]       ALU2;
    logic [2:0]       ALUop;
    logic             halted;
    logic             illegal;
    logic             bus_error;
    logic [CNT_W-1:0] retired;

    modport master (
        input  N, Z, instr, mem_ready,
        output PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload,
               R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite,
               ALU2, ALUop, halted, illegal, bus_error, retired
    );

    modport slave (
        output N, Z, instr, mem_ready,
        input  PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload,
               R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite,
               ALU2, ALUop, halted, illegal, bus_error, retired
    );
endinterface

// File: rtl/mc_control_hs.sv
// Multicycle control unit for the 4-bit-opcode processor with memory-ready
// handshake and timeout, sticky halt reasons and a retired-instruction counter.
module mc_control_hs #(
    parameter int unsigned WAIT_MAX        = 7,
    parameter int unsigned CNT_W           = 16,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    mc_control_hs_if.master   bus
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_ASN, S_SHIFT, S_WB, S_ORI_RD,
        S_ORI_EX, S_ORI_WB, S_LD_MEM, S_LD_WB, S_ST_MEM, S_BR, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ALU, OP_SHIFT, OP_ORI, OP_LOAD, OP_STORE, OP_BR, OP_NOP, OP_STOP, OP_ILL
    } op_class_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             mem_wait;
    op_class_t        op_class;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

    // shift and ori are keyed on the low three bits only, so they claim 3/11 and 7/15
    always_comb begin
        case (bus.instr)
            4'd0:                op_class = OP_LOAD;
            4'd1:                op_class = OP_STOP;
            4'd2:                op_class = OP_STORE;
            4'd4, 4'd6, 4'd8:    op_class = OP_ALU;
            4'd5, 4'd9, 4'd13:   op_class = OP_BR;
            4'd10:               op_class = OP_NOP;
            4'd3, 4'd11:         op_class = OP_SHIFT;
            4'd7, 4'd15:         op_class = OP_ORI;
            default:             op_class = OP_ILL;
        endcase
    end

    assign mem_wait = (state_q == S_FETCH || state_q == S_LD_MEM || state_q == S_ST_MEM)
                      && !bus.mem_ready;

    always_comb begin
        state_d         = state_q;
        wait_d          = '0;
        illegal_d       = illegal_q;
        bus_error_d     = bus_error_q;
        retire          = 1'b0;
        bus.PCwrite     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRload      = 1'b0;
        bus.R1Sel       = 1'b0;
        bus.MDRload     = 1'b0;
        bus.R1R2Load    = 1'b0;
        bus.ALU1        = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.RFWrite     = 1'b0;
        bus.RegIn       = 1'b0;
        bus.FlagWrite   = 1'b0;
        bus.ALU2        = 3'b000;
        bus.ALUop       = 3'b000;
        bus.halted      = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALU2    = 3'b001;
                if (bus.mem_ready) begin
                    bus.PCwrite = 1'b1;
                    bus.IRload  = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.R1R2Load = 1'b1;
                case (op_class)
                    OP_ALU:   state_d = S_ASN;
                    OP_SHIFT: state_d = S_SHIFT;
                    OP_ORI:   state_d = S_ORI_RD;
                    OP_LOAD:  state_d = S_LD_MEM;
                    OP_STORE: state_d = S_ST_MEM;
                    OP_BR:    state_d = S_BR;
                    OP_NOP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_STOP:  state_d = S_HALT;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end
                endcase
            end
            S_ASN: begin
                bus.ALU1        = 1'b1;
                bus.ALUOutWrite = 1'b1;
                bus.FlagWrite   = 1'b1;
                case (bus.instr)
                    4'd6:    bus.ALUop = 3'b001;
                    4'd8:    bus.ALUop = 3'b011;
                    default: bus.ALUop = 3'b000;
                endcase
                state_d = S_WB;
            end
            S_SHIFT: begin
                bus.ALU1        = 1'b1;
                bus.ALU2        = 3'b100;
                bus.ALUop       = 3'b100;
                bus.ALUOutWrite = 1'b1;
                bus.FlagWrite   = 1'b1;
                state_d         = S_WB;
            end
            S_WB: begin
                bus.RFWrite = 1'b1;
                state_d     = S_FETCH;
                retire      = 1'b1;
            end
            S_ORI_RD: begin
                bus.R1Sel    = 1'b1;
                bus.R1R2Load = 1'b1;
                state_d      = S_ORI_EX;
            end
            S_ORI_EX: begin
                bus.ALU1        = 1'b1;
                bus.ALU2        = 3'b011;
                bus.ALUop       = 3'b010;
                bus.ALUOutWrite = 1'b1;
                bus.FlagWrite   = 1'b1;
                state_d         = S_ORI_WB;
            end
            S_ORI_WB: begin
                bus.R1Sel   = 1'b1;
                bus.RFWrite = 1'b1;
                state_d     = S_FETCH;
                retire      = 1'b1;
            end
            S_LD_MEM: begin
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    bus.MDRload = 1'b1;
                    state_d     = S_LD_WB;
                end
            end
            S_LD_WB: begin
                bus.ALUOutWrite = 1'b1;
                bus.RFWrite     = 1'b1;
                bus.RegIn       = 1'b1;
                state_d         = S_FETCH;
                retire          = 1'b1;
            end
            S_ST_MEM: begin
                bus.MemWrite = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_BR: begin
                bus.ALU2 = 3'b010;
                case (bus.instr)
                    4'd5:    bus.PCwrite = bus.Z;
                    4'd9:    bus.PCwrite = ~bus.Z;
                    4'd13:   bus.PCwrite = ~bus.N;
                    default: bus.PCwrite = 1'b0;
                endcase
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: state_d = S_RESET;
        endcase

        // Counter only survives while a memory state keeps waiting; any exit clears it.
        if (mem_wait) begin
            if (wait_q == WAIT_LIM) begin
                state_d     = S_HALT;
                bus_error_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    assign retired_d     = retired_q + CNT_W'(retire);
    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_mc_control_hs.sv
// Directed bench for mc_control_hs: two instances cover the default and the
// small-counter / short-timeout / illegal-as-nop configurations.
module tb_mc_control_hs;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clock = ~clock;

    mc_control_hs_if #(.CNT_W(16)) ifa ();
    mc_control_hs_if #(.CNT_W(2))  ifb ();

    mc_control_hs #(.WAIT_MAX(7), .CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa)
    );
    mc_control_hs #(.WAIT_MAX(3), .CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb)
    );

    // Control vector: PCwrite MemRead MemWrite IRload R1Sel MDRload R1R2Load
    // ALU1 ALUOutWrite RFWrite RegIn FlagWrite ALU2[2:0] ALUop[2:0]
    localparam logic [17:0] PCW = 18'h20000, MRD = 18'h10000, MWR = 18'h08000;
    localparam logic [17:0] IRL = 18'h04000, R1S = 18'h02000, MDR = 18'h01000;
    localparam logic [17:0] RRL = 18'h00800, AL1 = 18'h00400, AOW = 18'h00200;
    localparam logic [17:0] RFW = 18'h00100, RGI = 18'h00080, FW  = 18'h00040;
    localparam logic [17:0] A2_1 = 18'd8, A2_2 = 18'd16, A2_3 = 18'd24, A2_4 = 18'd32;
    localparam logic [17:0] OP_1 = 18'd1, OP_2 = 18'd2, OP_3 = 18'd3, OP_4 = 18'd4;

    localparam logic [17:0] E_IDLE    = '0;
    localparam logic [17:0] E_FETCH_W = MRD | A2_1;
    localparam logic [17:0] E_FETCH_R = PCW | MRD | IRL | A2_1;
    localparam logic [17:0] E_DECODE  = RRL;
    localparam logic [17:0] E_WB      = RFW;
    localparam logic [17:0] E_BR_T    = PCW | A2_2;
    localparam logic [17:0] E_BR_N    = A2_2;
    localparam logic [17:0] E_ORI_RD  = R1S | RRL;
    localparam logic [17:0] E_ORI_EX  = AL1 | A2_3 | OP_2 | AOW | FW;
    localparam logic [17:0] E_LD_W    = MRD;
    localparam logic [17:0] E_LD_R    = MRD | MDR;
    localparam logic [17:0] E_LD_WB   = AOW | RFW | RGI;
    localparam logic [17:0] E_ST      = MWR;

    function automatic logic [17:0] ctl_a();
        return {ifa.PCwrite, ifa.MemRead, ifa.MemWrite, ifa.IRload, ifa.R1Sel, ifa.MDRload,
                ifa.R1R2Load, ifa.ALU1, ifa.ALUOutWrite, ifa.RFWrite, ifa.RegIn,
                ifa.FlagWrite, ifa.ALU2, ifa.ALUop};
    endfunction

    function automatic logic [17:0] ctl_b();
        return {ifb.PCwrite, ifb.MemRead, ifb.MemWrite, ifb.IRload, ifb.R1Sel, ifb.MDRload,
                ifb.R1R2Load, ifb.ALU1, ifb.ALUOutWrite, ifb.RFWrite, ifb.RegIn,
                ifb.FlagWrite, ifb.ALU2, ifb.ALUop};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  alu_ops [3];
        logic [17:0] alu_exp [3];
        logic [1:0]  nop_exp [5];
        int unsigned ret_a;

        alu_ops = '{4'd6, 4'd3, 4'd8};
        alu_exp = '{AL1 | AOW | FW | OP_1, AL1 | A2_4 | OP_4 | AOW | FW, AL1 | AOW | FW | OP_3};
        nop_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        ifa.N = 1'b0; ifa.Z = 1'b0; ifa.instr = 4'd4; ifa.mem_ready = 1'b1;
        ifb.N = 1'b0; ifb.Z = 1'b0; ifb.instr = 4'd10; ifb.mem_ready = 1'b1;

        // add with memory always ready
        reset = 1'b1;
        #3;
        check("in_reset_ctl", 32'(ctl_a()), 32'(E_IDLE));
        check("in_reset_halted", 32'(ifa.halted), 32'd0);
        do_reset();
        check("reset_state_ctl", 32'(ctl_a()), 32'(E_IDLE));
        check("reset_retired", ifa.retired, 32'd0);
        check("reset_flags", {30'd0, ifa.illegal, ifa.bus_error}, 32'd0);
        tick(); check("add_fetch", 32'(ctl_a()), 32'(E_FETCH_R));
        tick(); check("add_decode", 32'(ctl_a()), 32'(E_DECODE));
        tick(); check("add_asn", 32'(ctl_a()), 32'(AL1 | AOW | FW));
        tick(); check("add_wb", 32'(ctl_a()), 32'(E_WB));
        check("add_wb_retired", ifa.retired, 32'd0);
        tick(); check("add_fetch2", 32'(ctl_a()), 32'(E_FETCH_R));
        check("add_retired", ifa.retired, 32'd1);

        // fetch stretched by three not-ready cycles, then bz taken
        ifa.mem_ready = 1'b0; ifa.instr = 4'd5; ifa.Z = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("fetch_wait", 32'(ctl_a()), 32'(E_FETCH_W));
            tick();
        end
        ifa.mem_ready = 1'b1;
        #1;
        check("fetch_ready_c4", 32'(ctl_a()), 32'(E_FETCH_R));
        tick(); check("fetch_wait_decode", 32'(ctl_a()), 32'(E_DECODE));
        check("fetch_wait_no_buserr", 32'(ifa.bus_error), 32'd0);
        tick(); check("bz_taken", 32'(ctl_a()), 32'(E_BR_T));
        tick(); check("bz_retired", ifa.retired, 32'd2);

        ifa.instr = 4'd9;
        tick(); tick(); check("bnz_z1", 32'(ctl_a()), 32'(E_BR_N));
        tick(); check("bnz_retired", ifa.retired, 32'd3);
        ifa.instr = 4'd13; ifa.N = 1'b1;
        tick(); tick(); check("bpz_n1", 32'(ctl_a()), 32'(E_BR_N));
        tick(); check("bpz_retired", ifa.retired, 32'd4);

        // sub, shift, nand through WB
        ret_a = 4;
        for (int i = 0; i < 3; i++) begin
            ifa.instr = alu_ops[i];
            tick();
            tick(); check("alu_exec", 32'(ctl_a()), 32'(alu_exp[i]));
            tick(); check("alu_wb", 32'(ctl_a()), 32'(E_WB));
            tick(); ret_a++;
            check("alu_retired", ifa.retired, ret_a);
        end

        // store with one wait cycle
        ifa.instr = 4'd2;
        tick();
        ifa.mem_ready = 1'b0;
        tick(); check("st_wait", 32'(ctl_a()), 32'(E_ST));
        tick();
        ifa.mem_ready = 1'b1;
        #1;
        check("st_ready", 32'(ctl_a()), 32'(E_ST));
        tick(); check("st_retired", ifa.retired, 32'd8);

        // stop halts without marking illegal, and holds
        ifa.instr = 4'd1;
        tick(); tick();
        check("stop_halted", 32'(ifa.halted), 32'd1);
        check("stop_ctl", 32'(ctl_a()), 32'(E_IDLE));
        check("stop_flags", {30'd0, ifa.illegal, ifa.bus_error}, 32'd0);
        tick(); tick();
        check("stop_sticky", 32'(ifa.halted), 32'd1);
        check("stop_retired", ifa.retired, 32'd8);

        // illegal opcode halts (A)
        ifa.instr = 4'd12;
        do_reset();
        tick(); tick(); tick();
        check("ill_halted", 32'(ifa.halted), 32'd1);
        check("ill_flags", {30'd0, ifa.illegal, ifa.bus_error}, 32'd2);
        check("ill_retired", ifa.retired, 32'd0);

        // nop then ori, reset lands inside ORI_EX
        ifa.instr = 4'd10;
        do_reset();
        tick(); tick(); tick();
        check("nop_a_retired", ifa.retired, 32'd1);
        ifa.instr = 4'd7;
        tick();
        tick(); check("ori_rd", 32'(ctl_a()), 32'(E_ORI_RD));
        tick(); check("ori_ex", 32'(ctl_a()), 32'(E_ORI_EX));
        #2;
        reset = 1'b1;
        #1;
        check("midreset_ctl", 32'(ctl_a()), 32'(E_IDLE));
        check("midreset_retired", ifa.retired, 32'd0);
        check("midreset_halted", 32'(ifa.halted), 32'd0);
        #1;
        reset = 1'b0;

        // B: two-bit counter wraps through five nops
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick(); tick();
            check("nop_wrap", 32'(ifb.retired), 32'(nop_exp[i]));
        end

        // B: illegal executes as nop
        ifb.instr = 4'd12;
        tick(); tick();
        check("ill_nop_ctl", 32'(ctl_b()), 32'(E_FETCH_R));
        check("ill_nop_flags", {29'd0, ifb.halted, ifb.illegal, ifb.bus_error}, 32'd0);
        check("ill_nop_retired", 32'(ifb.retired), 32'd2);

        // B: load ready exactly on the last tolerated cycle
        ifb.instr = 4'd0;
        tick();
        ifb.mem_ready = 1'b0;
        tick(); check("ld_wait_c1", 32'(ctl_b()), 32'(E_LD_W));
        tick(); tick(); tick();
        ifb.mem_ready = 1'b1;
        #1;
        check("ld_ready_c4", 32'(ctl_b()), 32'(E_LD_R));
        tick(); check("ld_wb", 32'(ctl_b()), 32'(E_LD_WB));
        check("ld_edge_no_buserr", 32'(ifb.bus_error), 32'd0);
        tick(); check("ld_retired", 32'(ifb.retired), 32'd3);

        // B: load never ready times out after four LD_MEM cycles
        tick();
        ifb.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ld_to_wait", 32'({ifb.halted, ctl_b()}), 32'(E_LD_W));
        end
        tick();
        check("ld_to_halted", 32'(ifb.halted), 32'd1);
        check("ld_to_flags", {30'd0, ifb.illegal, ifb.bus_error}, 32'd1);
        check("ld_to_ctl", 32'(ctl_b()), 32'(E_IDLE));
        check("ld_to_retired", 32'(ifb.retired), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
